// File: rtl/mac_row_seq.sv
// mac_row_seq: sequencer feeding a 4-MAC FP16 row with weights, gap-free X bursts and latency-tracked results.
module mac_row_seq #(
    parameter int DW      = 16,
    parameter int ROW_LAT = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] n_vec,
    output logic             busy,
    output logic             done,
    input  logic [DW-1:0]    w_data,
    input  logic             w_valid,
    output logic             w_ready,
    input  logic [DW-1:0]    x_data,
    input  logic             x_valid,
    output logic             x_ready,
    output logic             row_enX,
    output logic [DW-1:0]    row_X,
    output logic [3:0]       row_enW,
    output logic [DW-1:0]    row_W,
    input  logic [DW-1:0]    row_Y,
    output logic [DW-1:0]    y_data,
    output logic             y_valid
);
    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, FINISH} state_t;
    state_t state, state_n;
    logic [CNT_W-1:0] nv, xa, iss, rcnt, xa_n, iss_n;
    logic [2:0] wcnt;
    logic [1:0] eidx, bidx, full, full_n;
    logic fb, ib, bbank, fb_n;
    logic [DW-1:0] xbuf [8];
    logic [ROW_LAT-1:0] trk;
    logic wacc, xacc, fill_done, issue, fin, clr;

    always_comb begin
        wacc      = w_valid && w_ready;
        xacc      = x_valid && x_ready;
        fill_done = xacc && eidx == 2'd3;
        issue     = state == STREAM && (!row_enX || bidx == 2'd3) && full[ib];
        fin       = trk[ROW_LAT-1] && rcnt + CNT_W'(1) == nv;
        clr       = abort || (state == IDLE && start);
        // a bank is released at issue: each element is read before the refill can reach it
        full_n = full;
        if (issue) full_n[ib] = 1'b0;
        if (fill_done) full_n[fb] = 1'b1;
        fb_n  = fb ^ fill_done;
        xa_n  = xa + CNT_W'(fill_done);
        iss_n = iss + CNT_W'(issue);
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = LOAD_W;
            LOAD_W:  if (wcnt == 3'd4) state_n = nv == '0 ? FINISH : STREAM;
            STREAM:  if (iss_n == nv) state_n = DRAIN;
            DRAIN:   if (fin) state_n = FINISH;
            default: state_n = IDLE;
        endcase
        if (abort) state_n = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (xacc) xbuf[{fb, eidx}] <= x_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            w_ready <= 1'b0;
            x_ready <= 1'b0;
            row_enX <= 1'b0;
            row_X   <= '0;
            row_enW <= '0;
            row_W   <= '0;
            y_data  <= '0;
            y_valid <= 1'b0;
            nv      <= '0;
            xa      <= '0;
            iss     <= '0;
            rcnt    <= '0;
            wcnt    <= '0;
            eidx    <= '0;
            bidx    <= '0;
            fb      <= 1'b0;
            ib      <= 1'b0;
            bbank   <= 1'b0;
            full    <= '0;
            trk     <= '0;
        end else begin
            busy    <= state_n != IDLE;
            done    <= state_n == FINISH;
            w_ready <= state_n == LOAD_W && !(wacc && wcnt == 3'd3);
            x_ready <= state_n == STREAM && !full_n[fb_n] && xa_n < nv;
            row_enW <= wacc ? 4'b1 << wcnt[1:0] : 4'b0;
            if (wacc) row_W <= w_data;
            if (trk[ROW_LAT-1]) y_data <= row_Y;
            if (state == IDLE && start && !abort) nv <= n_vec;
            if (clr) begin
                row_enX <= 1'b0;
                row_enW <= '0;
                y_valid <= 1'b0;
                xa      <= '0;
                iss     <= '0;
                rcnt    <= '0;
                wcnt    <= '0;
                eidx    <= '0;
                bidx    <= '0;
                fb      <= 1'b0;
                ib      <= 1'b0;
                full    <= '0;
                trk     <= '0;
            end else begin
                y_valid <= trk[ROW_LAT-1];
                if (wacc) wcnt <= wcnt + 3'd1;
                if (xacc) eidx <= eidx + 2'd1;
                full <= full_n;
                fb   <= fb_n;
                xa   <= xa_n;
                iss  <= iss_n;
                if (trk[ROW_LAT-1]) rcnt <= rcnt + CNT_W'(1);
                trk <= {trk[ROW_LAT-2:0], row_enX && bidx == 2'd0};
                if (issue) begin
                    row_enX <= 1'b1;
                    bbank   <= ib;
                    ib      <= !ib;
                    bidx    <= 2'd0;
                    row_X   <= xbuf[{ib, 2'd0}];
                end else if (row_enX && bidx != 2'd3) begin
                    bidx  <= bidx + 2'd1;
                    row_X <= xbuf[{bbank, bidx + 2'd1}];
                end else begin
                    row_enX <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mac_row_seq.sv
// tb_mac_row_seq: directed bench for mac_row_seq with a sliding-window FP16 row model driving row_Y.
module tb_mac_row_seq;
    localparam int DW = 16, ROW_LAT = 8, CNT_W = 16;
    logic clk = 0, reset_n = 0, start = 0, abort = 0;
    logic [CNT_W-1:0] n_vec = '0;
    logic busy, done, w_ready, x_ready, row_enX, y_valid;
    logic w_valid = 0, x_valid = 0;
    logic [DW-1:0] w_data = '0, x_data = '0, row_Y = '0;
    logic [DW-1:0] row_X, row_W, y_data;
    logic [3:0] row_enW;

    mac_row_seq #(.DW(DW), .ROW_LAT(ROW_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .n_vec(n_vec),
        .busy(busy), .done(done), .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
        .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready), .row_enX(row_enX), .row_X(row_X),
        .row_enW(row_enW), .row_W(row_W), .row_Y(row_Y), .y_data(y_data), .y_valid(y_valid)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    int bq[$], yt[$], wt[$], dq[$], runs[$];
    logic [15:0] yd[$], xq[$];
    logic [19:0] wv[$];
    int enx_cnt, run, busy_fall, v[8];
    logic prev_busy = 0;
    logic [15:0] wts [4], xs [12], yexp [4];
    int wacc_t [4];

    function automatic int val(input logic [15:0] x);
        case (x)
            16'h3C00: return 1;
            16'h4000: return 2;
            16'h4200: return 3;
            16'h4400: return 4;
            default:  return 0;
        endcase
    endfunction

    function automatic logic [15:0] enc(input int n);
        case (n)
            1: return 16'h3C00;   2: return 16'h4000;   3: return 16'h4200;   4: return 16'h4400;
            5: return 16'h4500;   6: return 16'h4600;   7: return 16'h4700;   8: return 16'h4800;
            9: return 16'h4880;  10: return 16'h4900;  11: return 16'h4980;  12: return 16'h4A00;
            13: return 16'h4A80; 14: return 16'h4B00;  15: return 16'h4B80;  16: return 16'h4C00;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Row model: weights 1.0, row_Y is the FP16 sum of the four enX cycles ending ROW_LAT-3 cycles ago.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (row_enX) begin
            if (enx_cnt % 4 == 0) bq.push_back(cyc);
            xq.push_back(row_X);
            enx_cnt++;
            run++;
        end else begin
            if (run > 0) runs.push_back(run);
            run = 0;
        end
        if (row_enW != 4'b0) begin
            wt.push_back(cyc);
            wv.push_back({row_enW, row_W});
        end
        if (y_valid) begin
            yt.push_back(cyc);
            yd.push_back(y_data);
        end
        if (done) dq.push_back(cyc);
        if (prev_busy && !busy) busy_fall = cyc;
        prev_busy = busy;
        row_Y = enc(v[4] + v[5] + v[6] + v[7]);
        for (int i = 7; i > 0; i--) v[i] = v[i-1];
        v[0] = row_enX ? val(row_X) : 0;
    endtask

    task automatic start_job(input int n);
        bq.delete(); yt.delete(); wt.delete(); dq.delete(); runs.delete();
        yd.delete(); xq.delete(); wv.delete();
        enx_cnt = 0; run = 0; busy_fall = -1;
        n_vec = CNT_W'(n);
        start = 1;
        step();
        start = 0;
        chk("busy_after_start", 64'(busy), 64'(1));
    endtask

    task automatic load_w(input bit gap);
        for (int k = 0; k < 4; k++) begin
            int n = 0;
            w_valid = 1;
            w_data = wts[k];
            while (!w_ready && n < 50) begin step(); n++; end
            chk("w_ready_seen", 64'(w_ready), 64'(1));
            wacc_t[k] = cyc;
            step();
            w_valid = 0;
            if (gap) step();
        end
    endtask

    task automatic stream_x(input int nel, input bit thr, input bit ab);
        int i = 0, n = 0;
        bit tog = 1, acc;
        while (i < nel && n < 400) begin
            x_valid = thr ? tog : 1'b1;
            x_data = xs[i];
            acc = x_valid && x_ready;
            step();
            n++;
            tog = !tog;
            if (acc) i++;
            if (ab && bq.size() == 2) begin
                x_valid = 0;
                abort = 1;
                step();
                abort = 0;
                return;
            end
        end
        x_valid = 0;
        chk("x_elems_accepted", 64'(i), 64'(nel));
    endtask

    task automatic wait_done();
        int n = 0;
        while (dq.size() == 0 && n < 200) begin step(); n++; end
        chk("done_seen", 64'(dq.size()), 64'(1));
        step();
    endtask

    task automatic check_job(input int n, input bit contig);
        int d, ly;
        chk("enx_cycles", 64'(enx_cnt), 64'(4 * n));
        chk("bursts", 64'(bq.size()), 64'(n));
        chk("results", 64'(yt.size()), 64'(n));
        for (int i = 0; i < n && i < yt.size() && i < bq.size(); i++) begin
            chk("y_latency", 64'(yt[i]), 64'(bq[i] + ROW_LAT + 1));
            chk("y_data", 64'(yd[i]), 64'(yexp[i]));
        end
        if (contig) begin
            chk("runs_contig", 64'(runs.size()), 64'(1));
            if (runs.size() > 0) chk("run_len_contig", 64'(runs[0]), 64'(4 * n));
        end else begin
            chk("runs_split", 64'(runs.size()), 64'(n));
            foreach (runs[i]) chk("run_len_4", 64'(runs[i]), 64'(4));
        end
        d = dq.size() > 0 ? dq[0] : -1;
        ly = yt.size() > 0 ? yt[yt.size()-1] : -2;
        chk("done_at_last_y", 64'(d), 64'(ly));
        chk("busy_fall", 64'(busy_fall), 64'(d + 1));
    endtask

    initial begin
        for (int i = 0; i < 8; i++) v[i] = 0;
        repeat (3) begin
            start = 1'($urandom); abort = 1'($urandom); n_vec = CNT_W'($urandom);
            w_valid = 1'($urandom); w_data = 16'($urandom);
            x_valid = 1'($urandom); x_data = 16'($urandom);
            step();
        end
        chk("reset_ctrl", 64'({busy, done, w_ready, x_ready, row_enX, row_enW, y_valid}), 64'(0));
        chk("reset_data", 64'({row_X, row_W, y_data}), 64'(0));
        start = 0; abort = 0; w_valid = 0; x_valid = 0; n_vec = '0;
        reset_n = 1;
        step();
        step();
        chk("idle_ready", 64'({w_ready, x_ready, busy}), 64'(0));

        start = 1; abort = 1; n_vec = CNT_W'(3);
        step();
        start = 0; abort = 0;
        chk("start_abort_busy", 64'(busy), 64'(0));
        chk("start_abort_wready", 64'(w_ready), 64'(0));
        step();

        // empty job with gapped weight beats
        wts[0] = 16'h3C00; wts[1] = 16'h4000; wts[2] = 16'h4200; wts[3] = 16'h4400;
        start_job(0);
        load_w(1);
        wait_done();
        chk("w_writes", 64'(wt.size()), 64'(4));
        for (int k = 0; k < 4 && k < wt.size(); k++) begin
            logic [3:0] oh;
            oh = 4'b1 << k;
            chk("w_write_cycle", 64'(wt[k]), 64'(wacc_t[k] + 1));
            chk("w_write_value", 64'(wv[k]), 64'({oh, wts[k]}));
        end
        chk("empty_enx", 64'(enx_cnt), 64'(0));
        chk("empty_results", 64'(yt.size()), 64'(0));
        if (dq.size() > 0 && wt.size() == 4) chk("empty_done_cycle", 64'(dq[0]), 64'(wt[3] + 1));
        chk("empty_busy_fall", 64'(busy_fall), 64'((dq.size() > 0 ? dq[0] : -1) + 1));
        repeat (3) step();

        for (int k = 0; k < 4; k++) begin wts[k] = 16'h3C00; yexp[k] = 16'h4400; end
        for (int i = 0; i < 12; i++) xs[i] = 16'h3C00;

        start_job(3);
        load_w(0);
        stream_x(12, 0, 0);
        wait_done();
        check_job(3, 1);
        if (bq.size() == 3) begin
            chk("b2b_burst1", 64'(bq[1] - bq[0]), 64'(4));
            chk("b2b_burst2", 64'(bq[2] - bq[1]), 64'(4));
        end
        repeat (3) step();

        start_job(3);
        load_w(0);
        stream_x(12, 1, 0);
        wait_done();
        check_job(3, 0);
        repeat (3) step();

        start_job(3);
        load_w(0);
        stream_x(12, 0, 1);
        chk("abort_enx", 64'(row_enX), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        repeat (40) step();
        chk("abort_no_y", 64'(yt.size()), 64'(0));
        chk("abort_no_done", 64'(dq.size()), 64'(0));
        chk("abort_idle_ready", 64'({w_ready, x_ready, busy}), 64'(0));

        start_job(3);
        load_w(0);
        stream_x(12, 0, 0);
        wait_done();
        check_job(3, 1);
        repeat (3) step();

        xs[0] = 16'h3C00; xs[1] = 16'h4000; xs[2] = 16'h4200; xs[3] = 16'h4400;
        for (int i = 4; i < 8; i++) xs[i] = 16'h4000;
        yexp[0] = 16'h4900; yexp[1] = 16'h4800;
        start_job(2);
        load_w(0);
        stream_x(8, 0, 0);
        wait_done();
        check_job(2, 1);
        chk("order_count", 64'(xq.size()), 64'(8));
        for (int i = 0; i < 8 && i < xq.size(); i++) chk("order_x", 64'(xq[i]), 64'(xs[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed cycle %0d required finish", cyc);
        $fatal(1, "timeout");
    end
endmodule
